// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit:
// FSM state enum, opcode constants and datapath select encodings.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FN   = 2'b10;

    // States whose exit to FETCH completes (retires) an instruction.
    function automatic logic is_retire_state(state_t s);
        return (s == S_MEMWB) || (s == S_MEMWRITE) ||
               (s == S_ALUWB) || (s == S_BEQ);
    endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control bundle between the main control FSM and the datapath.
// master: FSM side (drives selects/enables, reads opcode and flags).
// slave:  datapath side (drives opcode and flags, reads controls).
interface mc_control_fsm_if;

    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       zero;
    logic       mem_ready;

    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       illegal_instr;

    modport master (
        input  op, funct3, funct7_5, zero, mem_ready,
        output pc_write, adr_src, mem_write, ir_write,
        output result_src, alu_src_a, alu_src_b, alu_op,
        output reg_write, illegal_instr
    );

    modport slave (
        output op, funct3, funct7_5, zero, mem_ready,
        input  pc_write, adr_src, mem_write, ir_write,
        input  result_src, alu_src_a, alu_src_b, alu_op,
        input  reg_write, illegal_instr
    );

endinterface

// File: rtl/mc_ctrl_perf.sv
// Cycle and retired-instruction counters for the control FSM.
// Ports: clk, rst_n (sync, active-low), retire (1-cycle strobe),
// cycle_cnt / instret_cnt (32-bit, wrap at 2^32).
module mc_ctrl_perf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        retire,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
);

    logic [31:0] cycle_cnt_q;
    logic [31:0] cycle_cnt_d;
    logic [31:0] instret_cnt_q;
    logic [31:0] instret_cnt_d;

    always_comb begin
        cycle_cnt_d   = cycle_cnt_q + 32'd1;
        instret_cnt_d = instret_cnt_q;
        if (retire) begin
            instret_cnt_d = instret_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else begin
            cycle_cnt_q   <= cycle_cnt_d;
            instret_cnt_q <= instret_cnt_d;
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32I main control FSM (fetch/decode/execute/mem/wb).
// Ports: clk, rst_n (sync, active-low), bus (mc_control_fsm_if.master:
// op/funct/zero/mem_ready in, datapath selects and enables out).
// Option MC_CTRL_PERF_EN adds cycle_cnt / instret_cnt outputs.
module mc_control_fsm
    import mc_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    mc_control_fsm_if.master bus
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [31:0]      cycle_cnt,
    output logic [31:0]      instret_cnt
`endif
);

    state_t state_q;
    state_t state_d;
    state_t dec_state;

    logic       pc_update;
    logic       branch;
    logic       ir_en;
    logic       mem_we;
    logic       reg_we;
    logic       ill;
    logic       adr_sel;
    logic [1:0] res_sel;
    logic [1:0] a_sel;
    logic [1:0] b_sel;
    logic [1:0] aop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: begin
                state_d = bus.mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                case (bus.op)
                    OP_LW:   state_d = S_MEMADR;
                    OP_SW:   state_d = S_MEMADR;
                    OP_R:    state_d = S_EXECR;
                    OP_I:    state_d = S_EXECI;
                    OP_BEQ:  state_d = S_BEQ;
                    OP_JAL:  state_d = S_JAL;
                    default: state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                state_d = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                state_d = bus.mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: begin
                state_d = bus.mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_TRAP:     state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    // While reset is held the outputs show the FETCH decode, whatever
    // state the register currently holds.
    assign dec_state = rst_n ? state_q : S_FETCH;

    always_comb begin
        pc_update = 1'b0;
        branch    = 1'b0;
        ir_en     = 1'b0;
        mem_we    = 1'b0;
        reg_we    = 1'b0;
        ill       = 1'b0;
        adr_sel   = 1'b0;
        res_sel   = RES_ALUOUT;
        a_sel     = SRCA_PC;
        b_sel     = SRCB_RD2;
        aop       = ALUOP_ADD;
        case (dec_state)
            S_FETCH: begin
                a_sel     = SRCA_PC;
                b_sel     = SRCB_FOUR;
                res_sel   = RES_ALURES;
                ir_en     = bus.mem_ready;
                pc_update = bus.mem_ready;
            end
            S_DECODE: begin
                a_sel = SRCA_OLDPC;
                b_sel = SRCB_IMM;
            end
            S_MEMADR: begin
                a_sel = SRCA_RD1;
                b_sel = SRCB_IMM;
            end
            S_MEMREAD: begin
                adr_sel = 1'b1;
                res_sel = RES_ALUOUT;
            end
            S_MEMWB: begin
                res_sel = RES_DATA;
                reg_we  = 1'b1;
            end
            S_MEMWRITE: begin
                adr_sel = 1'b1;
                res_sel = RES_ALUOUT;
                mem_we  = 1'b1;
            end
            S_EXECR: begin
                a_sel = SRCA_RD1;
                b_sel = SRCB_RD2;
                aop   = ALUOP_FN;
            end
            S_EXECI: begin
                a_sel = SRCA_RD1;
                b_sel = SRCB_IMM;
                aop   = ALUOP_FN;
            end
            S_ALUWB: begin
                res_sel = RES_ALUOUT;
                reg_we  = 1'b1;
            end
            S_BEQ: begin
                a_sel   = SRCA_RD1;
                b_sel   = SRCB_RD2;
                aop     = ALUOP_SUB;
                res_sel = RES_ALUOUT;
                branch  = 1'b1;
            end
            S_JAL: begin
                a_sel     = SRCA_OLDPC;
                b_sel     = SRCB_FOUR;
                res_sel   = RES_ALUOUT;
                pc_update = 1'b1;
            end
            S_TRAP: begin
                ill = 1'b1;
            end
            default: begin
                ill = 1'b0;
            end
        endcase
    end

    assign bus.pc_write      = rst_n & (pc_update | (branch & bus.zero));
    assign bus.ir_write      = rst_n & ir_en;
    assign bus.mem_write     = rst_n & mem_we;
    assign bus.reg_write     = rst_n & reg_we;
    assign bus.illegal_instr = rst_n & ill;
    assign bus.adr_src       = adr_sel;
    assign bus.result_src    = res_sel;
    assign bus.alu_src_a     = a_sel;
    assign bus.alu_src_b     = b_sel;
    assign bus.alu_op        = aop;

`ifdef MC_CTRL_PERF_EN
    logic retire;

    // An instruction retires when a completing state hands back to FETCH.
    assign retire = rst_n && (state_d == S_FETCH) &&
                    is_retire_state(state_q);

    mc_ctrl_perf u_perf (
        .clk         (clk),
        .rst_n       (rst_n),
        .retire      (retire),
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
    );
`endif

endmodule
